fetch_stage: RTL and testbench

- Instruction fetch stage. Owns the PC and issues word requests to instruction memory.
- Buffers returned instructions in order and presents {pc, instr} to decode, which feeds the immediate generator and register file.
- Redirects from execute (taken branch, jal, jalr) squash all younger fetches.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_buf.sv | 79 +++++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned DEPTH_DEFAULT = 2;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// In-order FIFO of fetched {pc, instr} entries with a single-cycle flush.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_entry_t                 head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [DEPTH];
  logic            full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A pop frees the head slot in the same cycle, so push is allowed when full.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !clear && full && !pop))
    else $error("fetch_buf overflow");

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers responses in order.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misalign flag that halts fetch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic            fetch_misalign
`endif
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] discard_q, discard_d;
  logic [CntW-1:0] buf_count;
  logic [CntW:0]   occupancy;
  logic [XLEN-1:0] redirect_tgt;
  logic            req_fire, rsp_keep, buf_pop, buf_empty, halt;
  fetch_entry_t    buf_head, buf_push_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_set;

  assign misalign_set = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (misalign_set) begin
      misalign_q <= 1'b1;
    end
  end

  assign halt           = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign halt = 1'b0;
`endif

  // Low PC bits are never fetched from; the flag above is the only consumer of them.
  assign redirect_tgt = redirect_pc & ~32'h0000_0003;

  // Credit: every in-flight request must have a guaranteed buffer slot.
  assign occupancy      = {1'b0, inflight_q} + {1'b0, buf_count};
  assign imem_req_valid = !rst && !redirect_valid && !halt && (occupancy < (CntW+1)'(DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep      = imem_rsp_valid && !redirect_valid && (discard_q == '0);
  assign buf_push_data = '{pc: rsp_pc_q, instr: imem_rsp_data};

  // Decode is flushed alongside a redirect, so its handshake that cycle is void.
  assign if_valid = !buf_empty;
  assign buf_pop  = if_valid && if_ready && !redirect_valid;
  assign if_pc    = if_valid ? buf_head.pc    : '0;
  assign if_instr = if_valid ? buf_head.instr : NOP_INSTR;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_d      = redirect_tgt;
      rsp_pc_d  = redirect_tgt;
      discard_d = inflight_q - CntW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_next(pc_q);
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CntW'(1);
        end else begin
          rsp_pc_d = pc_next(rsp_pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .clear     (redirect_valid),
    .head      (buf_head),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  rsp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (inflight_q != '0))
    else $error("imem response without outstanding request");

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: memory model with variable latency, in-order expected stream.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t        pend[$];
  fetch_entry_t exp_q[$];
  int           tests, fails, pops, cyc;
  int           lat_min, lat_max;
  bit           rand_ready, rand_if_ready;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_min(input string name, input int act, input int min);
    tests++;
    if (act < min) begin
      fails++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // Decode should see a contiguous stream starting at base.
  task automatic expect_stream(input logic [31:0] base);
    logic [31:0] p;
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      p = base + 32'(4 * k);
      exp_q.push_back('{pc: p, instr: mem_word(p)});
    end
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic [31:0] stream_base);
    expect_stream(stream_base);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    check1("no_req_on_redirect", imem_req_valid, 1'b0);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  // Memory model: in-order responses, 1..3 cycle latency, optional random ready.
  initial begin
    bit          fire;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_req_ready = 1'b1;
    cyc            = 0;
    forever begin
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      a    = imem_addr;
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else begin
        if (fire) pend.push_back('{addr: a, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        imem_req_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        if (rand_if_ready) if_ready = 1'($urandom_range(1, 0));
      end
    end
  end

  // Monitor: every accepted decode entry must match the head of the expected stream.
  initial begin
    pops = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_valid && if_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_entry: got pc %h, none expected", if_pc);
          end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            check32("if_pc", if_pc, e.pc);
            check32("if_instr", if_instr, e.instr);
          end
        end else if (!if_valid) begin
          check32("idle_nop", if_instr, NOP);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          p0;
    int          n_exp;
    bit          found;
    logic [31:0] head_pc;
    tests = 0; fails = 0;
    lat_min = 1; lat_max = 1;
    rand_ready = 1'b0; rand_if_ready = 1'b0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b1;
    expect_stream(32'h0000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_req_valid", imem_req_valid, 1'b0);
    check1("rst_if_valid", if_valid, 1'b0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_instr", if_instr, NOP);
`ifdef FETCH_MISALIGN_CHECK_EN
    check1("rst_misalign", fetch_misalign, 1'b0);
`endif
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(negedge clk);
    check1("first_req_valid", imem_req_valid, 1'b1);
    check32("first_req_addr", imem_addr, 32'h0);

    // Streaming with 1-cycle memory
    p0 = pops;
    repeat (30) @(posedge clk);
    check_min("stream_pops", pops - p0, 10);

    // Decode stall: credit stops issue, head holds
    #2;
    if_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check1("stall_req_valid", imem_req_valid, 1'b0);
    check1("stall_if_valid", if_valid, 1'b1);
    check32("stall_buffered", 32'(u_dut.u_buf.count), DEPTH);
    check32("stall_head_pc", if_pc, exp_q[0].pc);
    head_pc = if_pc;
    repeat (3) @(negedge clk);
    check32("stall_head_stable", if_pc, head_pc);
    @(posedge clk);
    #2;
    if_ready = 1'b1;
    p0 = pops;
    repeat (20) @(posedge clk);
    check_min("release_pops", pops - p0, 8);

    // Redirect with requests in flight and no response this cycle
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #2;
      if (!imem_rsp_valid && pend.size() >= 2) found = 1'b1;
    end
    check1("found_inflight_window", found, 1'b1);
    n_exp = pend.size();
    p0 = pops;
    do_redirect(32'h0000_0100, 32'h0000_0100);
    @(negedge clk);
    check32("redir_discard", 32'(u_dut.discard_q), 32'(n_exp));
    check1("redir_empty", if_valid, 1'b0);
    repeat (20) @(posedge clk);
    check_min("redir_pops", pops - p0, 2);

    // Redirect coinciding with a response and a decode pop
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #2;
      if (imem_rsp_valid && if_valid && pend.size() >= 1) found = 1'b1;
    end
    check1("found_collision_window", found, 1'b1);
    n_exp = pend.size();
    do_redirect(32'h0000_0200, 32'h0000_0200);
    @(negedge clk);
    check1("collide_empty", if_valid, 1'b0);
    check32("collide_discard", 32'(u_dut.discard_q), 32'(n_exp));

    // Random memory stalls and latency, random decode stalls, one wrap-around redirect
    lat_min = 1; lat_max = 3;
    rand_ready = 1'b1; rand_if_ready = 1'b1;
    p0 = pops;
    repeat (150) @(posedge clk);
    #2;
`ifdef FETCH_MISALIGN_CHECK_EN
    do_redirect(32'hFFFF_FFF8, 32'hFFFF_FFF8);
`else
    do_redirect(32'hFFFF_FFFA, 32'hFFFF_FFF8);
`endif
    repeat (150) @(posedge clk);
    rand_ready = 1'b0; rand_if_ready = 1'b0;
    #2;
    if_ready = 1'b1;
    repeat (20) @(posedge clk);
    check_min("random_pops", pops - p0, 40);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts fetch for good
    #2;
    exp_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    check1("misalign_flag", fetch_misalign, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check1("misalign_no_req", imem_req_valid, 1'b0);
      check1("misalign_no_out", if_valid, 1'b0);
    end
    check1("misalign_sticky", fetch_misalign, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
